alu_top: RTL and testbench

- Register-fronted ALU. One shared input bus loads operand A, operand B and the opcode into three enable-gated registers.
- A combinational ALU works on the registered values and drives the result, zero and carry/borrow flags.
- Intended as the top of a small board-level ALU, where switches or buttons supply data and per-register load strobes.

---
 rtl/alu_top.sv | 110 +++++++++++
 tb/tb_alu_top.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_top.sv
// Register-fronted ALU: a shared data bus loads operand A, operand B and the opcode
// into enable-gated registers; a combinational ALU drives result, zero and carry/borrow.
module alu_top #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en_A,
    input  logic               i_en_B,
    input  logic               i_en_OP,
    input  logic [NB_DATA-1:0] i_data,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_zero,
    output logic               o_overflow
);

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

    logic [NB_DATA-1:0] reg_a_q,  reg_a_d;
    logic [NB_DATA-1:0] reg_b_q,  reg_b_d;
    logic [NB_OP-1:0]   reg_op_q, reg_op_d;

    logic [NB_DATA:0]   sum_s;
    logic [NB_DATA:0]   diff_s;
    logic [NB_DATA-1:0] result_s;
    logic               overflow_s;

    // Next-state selection for the operand and opcode registers.
    always_comb begin
        reg_a_d  = reg_a_q;
        reg_b_d  = reg_b_q;
        reg_op_d = reg_op_q;
        if (i_en_A) begin
            reg_a_d = i_data;
        end else begin
            reg_a_d = reg_a_q;
        end
        if (i_en_B) begin
            reg_b_d = i_data;
        end else begin
            reg_b_d = reg_b_q;
        end
        if (i_en_OP) begin
            reg_op_d = i_data[NB_OP-1:0];
        end else begin
            reg_op_d = reg_op_q;
        end
    end

    // Operand/opcode state; reset wins over every load strobe.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            reg_a_q  <= {NB_DATA{1'b0}};
            reg_b_q  <= {NB_DATA{1'b0}};
            reg_op_q <= {NB_OP{1'b0}};
        end else begin
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
            reg_op_q <= reg_op_d;
        end
    end

    // Extended-width add/subtract so bit NB_DATA carries the carry-out or borrow.
    always_comb begin
        sum_s  = {1'b0, reg_a_q} + {1'b0, reg_b_q};
        diff_s = {1'b0, reg_a_q} - {1'b0, reg_b_q};
    end

    // Opcode decode; undefined opcodes (including the reset value) yield zero.
    always_comb begin
        result_s   = {NB_DATA{1'b0}};
        overflow_s = 1'b0;
        case (reg_op_q)
            OP_ADD: begin
                result_s   = sum_s[NB_DATA-1:0];
                overflow_s = sum_s[NB_DATA];
            end
            OP_SUB: begin
                result_s   = diff_s[NB_DATA-1:0];
                overflow_s = diff_s[NB_DATA];
            end
            OP_AND: result_s = reg_a_q & reg_b_q;
            OP_OR:  result_s = reg_a_q | reg_b_q;
            OP_XOR: result_s = reg_a_q ^ reg_b_q;
            OP_NOR: result_s = ~(reg_a_q | reg_b_q);
            OP_SRA: result_s = {reg_a_q[NB_DATA-1], reg_a_q[NB_DATA-1:1]};
            OP_SRL: result_s = {1'b0, reg_a_q[NB_DATA-1:1]};
            default: begin
                result_s   = {NB_DATA{1'b0}};
                overflow_s = 1'b0;
            end
        endcase
    end

    // Outputs follow the registers combinationally.
    always_comb begin
        o_result   = result_s;
        o_overflow = overflow_s;
        o_zero     = (result_s == {NB_DATA{1'b0}});
    end

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: directed vector table, register-control
// sequences and random operand/opcode triples against an integer reference model.
module tb_alu_top;

    logic       i_clk;
    logic       i_rst;
    logic       i_en_A;
    logic       i_en_B;
    logic       i_en_OP;
    logic [7:0] i_data;
    logic [7:0] o_result;
    logic       o_zero;
    logic       o_overflow;

    int n_cmp;
    int n_err;

    alu_top #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en_A    (i_en_A),
        .i_en_B    (i_en_B),
        .i_en_OP   (i_en_OP),
        .i_data    (i_data),
        .o_result  (o_result),
        .o_zero    (o_zero),
        .o_overflow(o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] exp_res;
        logic       exp_zero;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[15];

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load(input logic ea, input logic eb, input logic eo, input logic [7:0] v);
        i_data  = v;
        i_en_A  = ea;
        i_en_B  = eb;
        i_en_OP = eo;
        step();
        i_en_A  = 1'b0;
        i_en_B  = 1'b0;
        i_en_OP = 1'b0;
    endtask

    task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        load(1'b1, 1'b0, 1'b0, a);
        load(1'b0, 1'b1, 1'b0, b);
        load(1'b0, 1'b0, 1'b1, {2'b00, op});
    endtask

    task automatic check(input string name, input logic [7:0] er, input logic ez, input logic eo);
        n_cmp++;
        if (o_result !== er || o_zero !== ez || o_overflow !== eo) begin
            n_err++;
            $display("FAIL %s: got result=%02h zero=%b ovf=%b, expected result=%02h zero=%b ovf=%b",
                     name, o_result, o_zero, o_overflow, er, ez, eo);
        end
    endtask

    // Independent integer reference model: returns {overflow, result}.
    function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        int ia;
        int ib;
        int r;
        logic ov;
        ia = int'(a);
        ib = int'(b);
        r  = 0;
        ov = 1'b0;
        case (op)
            6'd32: begin r = (ia + ib) % 256; ov = (ia + ib) > 255; end
            6'd34: begin r = (ia - ib + 256) % 256; ov = ia < ib; end
            6'd36: r = int'(a & b);
            6'd37: r = int'(a | b);
            6'd38: r = int'(a ^ b);
            6'd39: r = 255 - int'(a | b);
            6'd3:  r = ia / 2 + ((ia >= 128) ? 128 : 0);
            6'd2:  r = ia / 2;
            default: r = 0;
        endcase
        return {ov, 8'(r)};
    endfunction

    initial begin
        logic [5:0] ops[9];
        logic [7:0] ra;
        logic [7:0] rb;
        logic [5:0] rop;
        logic [8:0] exp;

        n_cmp   = 0;
        n_err   = 0;
        i_rst   = 1'b0;
        i_en_A  = 1'b0;
        i_en_B  = 1'b0;
        i_en_OP = 1'b0;
        i_data  = 8'h00;

        vecs[0]  = '{"add_carry",  8'd200, 8'd100, 6'b100000, 8'd44,  1'b0, 1'b1};
        vecs[1]  = '{"add_small",  8'd3,   8'd4,   6'b100000, 8'd7,   1'b0, 1'b0};
        vecs[2]  = '{"add_wrap0",  8'd255, 8'd1,   6'b100000, 8'd0,   1'b1, 1'b1};
        vecs[3]  = '{"sub_equal",  8'd7,   8'd7,   6'b100010, 8'd0,   1'b1, 1'b0};
        vecs[4]  = '{"sub_borrow", 8'd5,   8'd10,  6'b100010, 8'd251, 1'b0, 1'b1};
        vecs[5]  = '{"sub_0m1",    8'd0,   8'd1,   6'b100010, 8'd255, 1'b0, 1'b1};
        vecs[6]  = '{"sra_neg",    8'h81,  8'h55,  6'b000011, 8'hC0,  1'b0, 1'b0};
        vecs[7]  = '{"srl",        8'h81,  8'hFF,  6'b000010, 8'h40,  1'b0, 1'b0};
        vecs[8]  = '{"sra_pos",    8'h7F,  8'hAA,  6'b000011, 8'h3F,  1'b0, 1'b0};
        vecs[9]  = '{"and",        8'hF0,  8'h3C,  6'b100100, 8'h30,  1'b0, 1'b0};
        vecs[10] = '{"or",         8'hF0,  8'h3C,  6'b100101, 8'hFC,  1'b0, 1'b0};
        vecs[11] = '{"xor",        8'hF0,  8'h3C,  6'b100110, 8'hCC,  1'b0, 1'b0};
        vecs[12] = '{"nor",        8'hF0,  8'h3C,  6'b100111, 8'h03,  1'b0, 1'b0};
        vecs[13] = '{"nor_zero",   8'hFF,  8'h00,  6'b100111, 8'h00,  1'b1, 1'b0};
        vecs[14] = '{"illegal",    8'd5,   8'd3,   6'b111111, 8'h00,  1'b1, 1'b0};

        // Reset held three edges.
        step(); step(); step();
        i_rst = 1'b1;
        step();
        check("reset_state", 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].op);
            check(vecs[i].name, vecs[i].exp_res, vecs[i].exp_zero, vecs[i].exp_ovf);
        end

        // Bus activity without enables must not disturb outputs.
        apply(8'd200, 8'd100, 6'b100000);
        i_data = 8'h00; step();
        i_data = 8'hFF; step();
        i_data = 8'h22; step();
        check("no_enable_hold", 8'd44, 1'b0, 1'b1);

        // Single-register reload keeps the other operands.
        load(1'b0, 1'b1, 1'b0, 8'd55);
        check("reload_b_only", 8'd255, 1'b0, 1'b0);

        // Simultaneous enables: A=B=0x20, OP=0x20 -> ADD.
        load(1'b1, 1'b1, 1'b1, 8'h20);
        check("all_enables", 8'h40, 1'b0, 1'b0);

        // Reset mid-sequence discards loaded state, even with enables high.
        apply(8'd200, 8'd100, 6'b100000);
        i_rst   = 1'b0;
        i_en_A  = 1'b1;
        i_en_B  = 1'b1;
        i_en_OP = 1'b1;
        i_data  = 8'h20;
        step();
        i_en_A  = 1'b0;
        i_en_B  = 1'b0;
        i_en_OP = 1'b0;
        check("reset_override", 8'h00, 1'b1, 1'b0);
        i_rst = 1'b1;
        load(1'b1, 1'b0, 1'b0, 8'd9);
        load(1'b0, 1'b0, 1'b1, 8'h20);
        check("post_reset_b0", 8'd9, 1'b0, 1'b0);

        ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                6'b100111, 6'b000011, 6'b000010, 6'b000000};
        for (int k = 0; k < 50; k++) begin
            ra  = 8'($urandom_range(255, 0));
            rb  = 8'($urandom_range(255, 0));
            rop = (k % 10 == 9) ? 6'($urandom_range(63, 0)) : ops[$urandom_range(8, 0)];
            apply(ra, rb, rop);
            exp = ref_alu(ra, rb, rop);
            check($sformatf("rand%0d_op%06b", k, rop), exp[7:0], exp[7:0] == 8'h00, exp[8]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
